poly_note_player: RTL and testbench

- Parametrised successor to note_player: plays up to NUM_VOICES notes at once (chords).
- Each note is loaded into a free voice slot with its own beat-driven duration counter and phase accumulator.
- Voices produce triangle waves that are summed and scaled into one sample stream.
- Sits between the song reader (note/duration loads) and the codec sample path (generate_next_sample / new_sample_ready), driven by the shared beat_generator.

---
 rtl/poly_note_player_pkg.sv | 43 ++++
 rtl/poly_note_player_voice_slot.sv | 71 +++++++
 rtl/poly_note_player.sv | 100 ++++++++++
 tb/tb_poly_note_player.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_note_player_pkg.sv
// Shared types, constants and helper functions for the polyphonic note player.
package poly_note_player_pkg;

   localparam int unsigned DEF_NUM_VOICES = 4;
   localparam int unsigned VOICE_SHIFT    = $clog2(DEF_NUM_VOICES);
   localparam int unsigned STEP_WIDTH     = 20;

   // Phase step per sample for a note code: A1 (55 Hz) at note 1, equal
   // temperament, 48 kHz sample rate, 20-bit phase. Each octave doubles the step.
   function automatic logic [STEP_WIDTH-1:0] step_table(input logic [5:0] note);
      logic [11:0] base;
      logic [5:0]  idx;
      logic [2:0]  oct;
      idx = note - 6'd1;
      oct = 3'(idx / 6'd12);
      unique case (idx % 6'd12)
         6'd0:    base = 12'd1201;
         6'd1:    base = 12'd1273;
         6'd2:    base = 12'd1349;
         6'd3:    base = 12'd1429;
         6'd4:    base = 12'd1514;
         6'd5:    base = 12'd1604;
         6'd6:    base = 12'd1699;
         6'd7:    base = 12'd1800;
         6'd8:    base = 12'd1907;
         6'd9:    base = 12'd2021;
         6'd10:   base = 12'd2141;
         default: base = 12'd2268;
      endcase
      if (note == 6'd0)
         step_table = '0;
      else
         step_table = STEP_WIDTH'(base) << oct;
   endfunction

   // Triangle fold of a width-bit ramp: mirror the upper half, drop the MSB.
   function automatic logic [31:0] tri_fold(input logic [31:0] u, input int unsigned width);
      logic [31:0] mask;
      mask     = (32'd1 << (width - 1)) - 32'd1;
      tri_fold = (u[width-1] ? ~u : u) & mask;
   endfunction

endpackage

// File: rtl/poly_note_player_voice_slot.sv
// One voice slot: busy flag, beat-driven duration counter, phase accumulator
// and registered triangle sample.
module np_voice_slot
   import poly_note_player_pkg::*;
#(
   parameter int unsigned NOTE_WIDTH   = 6,
   parameter int unsigned DUR_WIDTH    = 6,
   parameter int unsigned PHASE_WIDTH  = 20,
   parameter int unsigned SAMPLE_WIDTH = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           load,
   input  logic [NOTE_WIDTH-1:0]          note_in,
   input  logic [DUR_WIDTH-1:0]           dur_in,
   input  logic                           beat_en,
   input  logic                           adv,
   output logic                           busy,
   output logic                           finishing,
   output logic signed [SAMPLE_WIDTH-1:0] voice
);

   logic [NOTE_WIDTH-1:0]   note;
   logic [DUR_WIDTH-1:0]    dur;
   logic [PHASE_WIDTH-1:0]  step;
   logic [PHASE_WIDTH-1:0]  phase;
   logic [PHASE_WIDTH-1:0]  next_phase;
   logic [SAMPLE_WIDTH-1:0] ramp;
   logic [31:0]             fold;
   logic [SAMPLE_WIDTH-1:0] wave;

   // Triangle sample derived from the advanced phase
   always_comb begin
      next_phase = phase + step;
      ramp       = next_phase[PHASE_WIDTH-1 -: SAMPLE_WIDTH];
      fold       = tri_fold(32'(ramp), SAMPLE_WIDTH);
      wave       = SAMPLE_WIDTH'(fold << 1) - {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
   end

   assign finishing = busy && beat_en && (dur == DUR_WIDTH'(1));

   // Slot state: load, beat countdown, phase advance and voice sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy  <= 1'b0;
         note  <= '0;
         dur   <= '0;
         step  <= '0;
         phase <= '0;
         voice <= '0;
      end else begin
         if (load) begin
            busy  <= 1'b1;
            note  <= note_in;
            dur   <= dur_in;
            step  <= PHASE_WIDTH'(step_table(6'(note_in)));
            phase <= '0;
         end else if (busy && beat_en) begin
            dur <= dur - DUR_WIDTH'(1);
            if (dur == DUR_WIDTH'(1))
               busy <= 1'b0;
         end
         if (adv) begin
            if (busy)
               phase <= next_phase;
            voice <= (busy && note != '0) ? wave : '0;
         end
      end
   end

endmodule

// File: rtl/poly_note_player.sv
// Polyphonic note player: allocates notes to free voice slots and mixes the
// per-voice triangle samples into one signed sample stream.
module poly_note_player
   import poly_note_player_pkg::*;
#(
   parameter int unsigned NUM_VOICES   = DEF_NUM_VOICES,
   parameter int unsigned NOTE_WIDTH   = 6,
   parameter int unsigned DUR_WIDTH    = 6,
   parameter int unsigned PHASE_WIDTH  = 20,
   parameter int unsigned SAMPLE_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    play_enable,
   input  logic [NOTE_WIDTH-1:0]   note_to_load,
   input  logic [DUR_WIDTH-1:0]    duration_to_load,
   input  logic                    load_new_note,
   output logic                    load_rejected,
   output logic                    voices_full,
   output logic [NUM_VOICES-1:0]   active_voices,
   output logic                    done_with_note,
   input  logic                    beat,
   input  logic                    generate_next_sample,
   output logic [SAMPLE_WIDTH-1:0] sample_out,
   output logic                    new_sample_ready
);

   localparam int unsigned SHIFT = $clog2(NUM_VOICES);
   localparam int unsigned SUMW  = SAMPLE_WIDTH + SHIFT;

   logic                           beat_en;
   logic                           adv;
   logic                           load_ok;
   logic                           mix_pending;
   logic [NUM_VOICES-1:0]          free_slots;
   logic [NUM_VOICES-1:0]          slot_load;
   logic [NUM_VOICES-1:0]          finishing;
   logic signed [SAMPLE_WIDTH-1:0] voice [NUM_VOICES];
   logic signed [SUMW-1:0]         sum;
   logic [SAMPLE_WIDTH-1:0]        mixed;

   assign beat_en     = beat && play_enable;
   assign adv         = generate_next_sample && play_enable;
   assign voices_full = &active_voices;

   // Lowest free slot wins a valid load; occupancy comes from registered flags
   always_comb begin
      free_slots = ~active_voices;
      load_ok    = load_new_note && (duration_to_load != '0) && !voices_full;
      // x & -x isolates the lowest set bit, i.e. the lowest-index free slot
      slot_load  = load_ok ? (free_slots & (~free_slots + NUM_VOICES'(1))) : '0;
   end

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
      np_voice_slot #(
         .NOTE_WIDTH  (NOTE_WIDTH),
         .DUR_WIDTH   (DUR_WIDTH),
         .PHASE_WIDTH (PHASE_WIDTH),
         .SAMPLE_WIDTH(SAMPLE_WIDTH)
      ) u_slot (
         .clk      (clk),
         .rst      (reset),
         .load     (slot_load[g]),
         .note_in  (note_to_load),
         .dur_in   (duration_to_load),
         .beat_en  (beat_en),
         .adv      (adv),
         .busy     (active_voices[g]),
         .finishing(finishing[g]),
         .voice    (voice[g])
      );
   end

   // Signed mix of all voice samples, scaled back to sample width
   always_comb begin
      sum = '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++)
         sum = sum + SUMW'(voice[i]);
      mixed = SAMPLE_WIDTH'(sum >>> SHIFT);
   end

   // Output stage: mix register, ready pulse, load/finish status pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mix_pending      <= 1'b0;
         new_sample_ready <= 1'b0;
         sample_out       <= '0;
         load_rejected    <= 1'b0;
         done_with_note   <= 1'b0;
      end else begin
         mix_pending      <= adv;
         new_sample_ready <= mix_pending;
         if (mix_pending)
            sample_out <= mixed;
         load_rejected  <= load_new_note && !load_ok;
         done_with_note <= |finishing;
      end
   end

endmodule

// File: tb/tb_poly_note_player.sv
// Scoreboard bench for poly_note_player against a slot-level reference model.
module tb_poly_note_player;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        play_enable = 1'b1;
   logic [5:0]  note_to_load = '0;
   logic [5:0]  duration_to_load = '0;
   logic        load_new_note = 1'b0;
   logic        beat = 1'b0;
   logic        generate_next_sample = 1'b0;
   logic        load_rejected;
   logic        voices_full;
   logic [3:0]  active_voices;
   logic        done_with_note;
   logic [15:0] sample_out;
   logic        new_sample_ready;

   poly_note_player #(
      .NUM_VOICES  (4),
      .NOTE_WIDTH  (6),
      .DUR_WIDTH   (6),
      .PHASE_WIDTH (20),
      .SAMPLE_WIDTH(16)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .play_enable         (play_enable),
      .note_to_load        (note_to_load),
      .duration_to_load    (duration_to_load),
      .load_new_note       (load_new_note),
      .load_rejected       (load_rejected),
      .voices_full         (voices_full),
      .active_voices       (active_voices),
      .done_with_note      (done_with_note),
      .beat                (beat),
      .generate_next_sample(generate_next_sample),
      .sample_out          (sample_out),
      .new_sample_ready    (new_sample_ready)
   );

   always #5 clk = ~clk;

   typedef struct { bit [3:0] act; bit rej; bit done; } exp_t;
   typedef struct { int val; int due; } samp_t;
   exp_t  exp_q[$];
   samp_t samp_q[$];

   int tests = 0;
   int fails = 0;
   int edge_cnt = 0;
   int last_val = 0;

   // Reference model: one entry per voice slot
   bit          m_busy  [4];
   int          m_note  [4];
   int          m_dur   [4];
   int unsigned m_phase [4];

   int base_step [12] = '{1201, 1273, 1349, 1429, 1514, 1604,
                          1699, 1800, 1907, 2021, 2141, 2268};

   function automatic int step_of(int n);
      if (n == 0) return 0;
      return base_step[(n - 1) % 12] * (1 << ((n - 1) / 12));
   endfunction

   // Triangle: rises -32768..32766 over the first half of the cycle, falls back after
   function automatic int tri_val(int unsigned ph);
      int u;
      u = int'(ph >> 4);
      if (u < 32768) return 2 * u - 32768;
      return 2 * (65535 - u) - 32768;
   endfunction

   task automatic check(string name, int act, int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Monitor: compares per-edge status and every presented sample
   always @(negedge clk) begin
      exp_t  e;
      samp_t s;
      if (reset) begin
         last_val = 0;
      end else begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("active_voices", int'(active_voices), int'(e.act));
            check("voices_full", int'(voices_full), int'(&e.act));
            check("load_rejected", int'(load_rejected), int'(e.rej));
            check("done_with_note", int'(done_with_note), int'(e.done));
         end
         if (new_sample_ready) begin
            if (samp_q.size() == 0) begin
               check("unexpected_sample", 1, 0);
            end else begin
               s = samp_q.pop_front();
               check("sample_value", int'($signed(sample_out)), s.val);
               check("sample_latency", edge_cnt, s.due);
               last_val = s.val;
            end
         end else begin
            check("sample_hold", int'($signed(sample_out)), last_val);
            if (samp_q.size() > 0 && samp_q[0].due <= edge_cnt) begin
               check("missing_sample", 0, 1);
               void'(samp_q.pop_front());
            end
         end
      end
   end

   // One clock of stimulus; the model predicts the effect of the coming edge
   task automatic cyc(input bit ld, input int n, input int d, input bit bt, input bit gn);
      exp_t e;
      int   free_i;
      bit   acc;
      int   sum;
      load_new_note        = ld;
      note_to_load         = 6'(n);
      duration_to_load     = 6'(d);
      beat                 = bt;
      generate_next_sample = gn;
      free_i = -1;
      for (int i = 3; i >= 0; i--)
         if (!m_busy[i]) free_i = i;
      acc    = ld && d != 0 && free_i >= 0;
      e.rej  = ld && !acc;
      e.done = 1'b0;
      if (gn && play_enable) begin
         sum = 0;
         for (int i = 0; i < 4; i++) begin
            if (m_busy[i]) begin
               m_phase[i] = (m_phase[i] + int'(step_of(m_note[i]))) & 32'hFFFFF;
               if (m_note[i] != 0) sum += tri_val(m_phase[i]);
            end
         end
         samp_q.push_back('{sum >>> 2, edge_cnt + 2});
      end
      if (bt && play_enable) begin
         for (int i = 0; i < 4; i++) begin
            if (m_busy[i]) begin
               m_dur[i]--;
               if (m_dur[i] == 0) begin
                  m_busy[i] = 1'b0;
                  e.done    = 1'b1;
               end
            end
         end
      end
      if (acc) begin
         m_busy[free_i]  = 1'b1;
         m_note[free_i]  = n;
         m_dur[free_i]   = d;
         m_phase[free_i] = 0;
      end
      for (int i = 0; i < 4; i++) e.act[i] = m_busy[i];
      @(posedge clk);
      exp_q.push_back(e);
      #1;
   endtask

   // Asynchronous reset asserted mid-cycle; everything must clear at once
   task automatic do_reset();
      #2 reset = 1'b1;
      #1;
      check("rst_active_voices", int'(active_voices), 0);
      check("rst_voices_full", int'(voices_full), 0);
      check("rst_load_rejected", int'(load_rejected), 0);
      check("rst_done_with_note", int'(done_with_note), 0);
      check("rst_new_sample_ready", int'(new_sample_ready), 0);
      check("rst_sample_out", int'(sample_out), 0);
      for (int i = 0; i < 4; i++) begin
         m_busy[i] = 1'b0; m_note[i] = 0; m_dur[i] = 0; m_phase[i] = 0;
      end
      exp_q.delete();
      samp_q.delete();
      load_new_note = 1'b0; beat = 1'b0; generate_next_sample = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4; i++) begin
         m_busy[i] = 1'b0; m_note[i] = 0; m_dur[i] = 0; m_phase[i] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      check("init_active_voices", int'(active_voices), 0);
      check("init_sample_out", int'(sample_out), 0);
      check("init_new_sample_ready", int'(new_sample_ready), 0);
      check("init_load_rejected", int'(load_rejected), 0);
      reset = 1'b0;

      // Reset in the middle of a note
      cyc(1, 5, 5, 0, 0);
      cyc(0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      do_reset();

      // Duration: busy for exactly 5 beats
      cyc(1, 5, 5, 0, 0);
      for (int k = 0; k < 5; k++) begin
         cyc(0, 0, 0, 0, 0);
         cyc(0, 0, 0, 1, 1);
      end
      cyc(0, 0, 0, 0, 0);

      // Polyphony, full, rejected loads
      for (int k = 0; k < 4; k++) cyc(1, 10 + k, 8, 0, 1);
      cyc(1, 3, 4, 0, 0);
      cyc(1, 3, 0, 0, 0);
      for (int k = 0; k < 9; k++) cyc(0, 0, 0, 1, 1);
      cyc(1, 3, 0, 0, 0);

      // Pause: in-flight sample completes, then everything freezes
      cyc(1, 5, 5, 0, 0);
      cyc(0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 1);
      play_enable = 1'b0;
      for (int k = 0; k < 20; k++) cyc(0, 0, 0, k % 2 == 0, 1'b1);
      play_enable = 1'b1;
      for (int k = 0; k < 5; k++) cyc(0, 0, 0, 1, 1);

      // Rest note only: silent output, two-cycle latency
      do_reset();
      cyc(1, 0, 40, 0, 0);
      for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0, k % 3 != 2);

      // Notes 5 and 17 mixed over 1000 samples
      do_reset();
      cyc(1, 5, 63, 0, 0);
      cyc(1, 17, 63, 0, 0);
      for (int k = 0; k < 1000; k++) cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);

      // Slot freeing on the same edge as a load is not reusable yet
      do_reset();
      cyc(1, 5, 1, 0, 0);
      cyc(1, 6, 9, 0, 0);
      cyc(1, 7, 9, 0, 0);
      cyc(1, 8, 9, 0, 0);
      cyc(1, 9, 9, 1, 0);
      cyc(1, 9, 9, 0, 0);
      cyc(0, 0, 0, 0, 1);

      // Randomized traffic
      do_reset();
      for (int k = 0; k < 2000; k++) begin
         play_enable = ($urandom % 8) != 0;
         cyc($urandom % 3 == 0, int'($urandom % 64), int'($urandom % 8),
             $urandom % 4 == 0, $urandom % 2 == 1);
      end
      play_enable = 1'b1;
      for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0);
      check("samples_drained", samp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
